// File: rtl/fp_unpack_seq_if.sv
// Operand/result handshake bundle for fp_unpack_seq.
// slave is the unpacker side, master is the producer/consumer side.
interface fp_unpack_seq_if #(
    parameter int N_EXP = 11,
    parameter int N_MAN = 52
);
    logic                    in_valid;
    logic                    in_ready;
    logic [N_EXP+N_MAN:0]    in_f;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_sign;
    logic signed [N_EXP+1:0] out_exp;
    logic [N_MAN:0]          out_man;
    logic                    out_zero;
    logic                    out_inf;
    logic                    out_qnan;
    logic                    out_snan;
    logic                    out_dnorm;
    logic                    out_norm;

    modport slave (
        input  in_valid, in_f, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_man,
               out_zero, out_inf, out_qnan, out_snan, out_dnorm, out_norm
    );

    modport master (
        output in_valid, in_f, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_man,
               out_zero, out_inf, out_qnan, out_snan, out_dnorm, out_norm
    );
endinterface

// File: rtl/fp_unpack_seq.sv
// Handshaked FP operand unpacker: classifies, unbiases the exponent and
// normalises denormals iteratively so downstream datapaths see a leading one.
module fp_unpack_seq #(
    parameter int N_EXP = 11,
    parameter int N_MAN = 52,
    parameter int BIAS  = (1 << (N_EXP - 1)) - 1,
    parameter int EMIN  = 1 - BIAS,
    parameter int STEP  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    fp_unpack_seq_if.slave bus
);
    localparam int NE = N_EXP + 2;
    localparam logic signed [NE-1:0] BIAS_E = NE'(BIAS);
    localparam logic signed [NE-1:0] INF_E  = NE'(BIAS + 1);
    localparam logic signed [NE-1:0] EMIN_E = NE'(EMIN);
    localparam logic signed [NE-1:0] STEP_E = NE'(STEP);
    localparam logic signed [NE-1:0] ONE_E  = NE'(1);

    typedef enum logic [1:0] {IDLE, SHIFT, OUT} state_t;
    state_t state, state_n;

    logic                 sign_q;
    logic signed [NE-1:0] exp_q;
    logic [N_MAN:0]       man_q;
    logic                 zero_q, inf_q, qnan_q, snan_q, dnorm_q, norm_q;

    logic                 f_sign;
    logic [N_EXP-1:0]     f_exp;
    logic [N_MAN-1:0]     f_frac;
    logic                 e1, e0, f0, is_dn, accept;
    logic signed [NE-1:0] ld_exp, sh_exp;
    logic [N_MAN:0]       ld_man, sh_man;

    assign f_sign = bus.in_f[N_EXP+N_MAN];
    assign f_exp  = bus.in_f[N_MAN +: N_EXP];
    assign f_frac = bus.in_f[N_MAN-1:0];
    assign e1     = &f_exp;
    assign e0     = ~|f_exp;
    assign f0     = ~|f_frac;
    assign is_dn  = e0 & ~f0;

    // Gated by rst_n so nothing is accepted while reset is held.
    assign bus.in_ready = rst_n & ((state == IDLE) | ((state == OUT) & bus.out_ready));
    assign accept       = bus.in_valid & bus.in_ready;
    assign bus.out_valid = (state == OUT);

    always_comb begin
        ld_exp = '0;
        ld_man = {1'b0, f_frac};
        if (e1) begin
            ld_exp = INF_E;
        end else if (e0) begin
            ld_exp = f0 ? '0 : EMIN_E;
        end else begin
            ld_exp = $signed({2'b00, f_exp}) - BIAS_E;
            ld_man = {1'b1, f_frac};
        end
    end

    // Coarse step only when the top STEP bits are clear, so it never overshoots.
    always_comb begin
        sh_man = man_q << 1;
        sh_exp = exp_q - ONE_E;
        if (man_q[N_MAN -: STEP] == '0) begin
            sh_man = man_q << STEP;
            sh_exp = exp_q - STEP_E;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (accept) state_n = is_dn ? SHIFT : OUT;
            SHIFT: if (sh_man[N_MAN]) state_n = OUT;
            OUT: begin
                if (accept)              state_n = is_dn ? SHIFT : OUT;
                else if (bus.out_ready)  state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q  <= 1'b0;
            exp_q   <= '0;
            man_q   <= '0;
            zero_q  <= 1'b0;
            inf_q   <= 1'b0;
            qnan_q  <= 1'b0;
            snan_q  <= 1'b0;
            dnorm_q <= 1'b0;
            norm_q  <= 1'b0;
        end else if (accept) begin
            sign_q  <= f_sign;
            exp_q   <= ld_exp;
            man_q   <= ld_man;
            zero_q  <= e0 & f0;
            inf_q   <= e1 & f0;
            qnan_q  <= e1 & ~f0 & f_frac[N_MAN-1];
            snan_q  <= e1 & ~f0 & ~f_frac[N_MAN-1];
            dnorm_q <= is_dn;
            norm_q  <= ~e1 & ~e0;
        end else if (state == SHIFT) begin
            man_q <= sh_man;
            exp_q <= sh_exp;
        end
    end

    assign bus.out_sign  = sign_q;
    assign bus.out_exp   = exp_q;
    assign bus.out_man   = man_q;
    assign bus.out_zero  = zero_q;
    assign bus.out_inf   = inf_q;
    assign bus.out_qnan  = qnan_q;
    assign bus.out_snan  = snan_q;
    assign bus.out_dnorm = dnorm_q;
    assign bus.out_norm  = norm_q;
endmodule

// File: tb/tb_fp_unpack_seq.sv
// Directed bench for fp_unpack_seq (binary64 configuration) with a result scoreboard.
`timescale 1ns/1ps
module tb_fp_unpack_seq;
    localparam int N_EXP = 11;
    localparam int N_MAN = 52;
    localparam int STEP  = 4;

    typedef struct {
        logic        sign;
        int          exp;
        logic [52:0] man;
        logic [5:0]  cls;   // {zero, inf, qnan, snan, dnorm, norm}
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fp_unpack_seq_if #(.N_EXP(N_EXP), .N_MAN(N_MAN)) bus ();

    fp_unpack_seq #(.N_EXP(N_EXP), .N_MAN(N_MAN), .STEP(STEP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] req);
        n_vec++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, req);
        end
    endtask

    function automatic logic [5:0] cls_now();
        return {bus.out_zero, bus.out_inf, bus.out_qnan, bus.out_snan, bus.out_dnorm, bus.out_norm};
    endfunction

    function automatic exp_t model(input logic [63:0] f);
        exp_t        r;
        logic [10:0] e;
        logic [51:0] fr;
        int          lz;
        e      = f[62:52];
        fr     = f[51:0];
        r.sign = f[63];
        r.exp  = 0;
        r.man  = '0;
        r.lat  = 1;
        r.cls  = '0;
        if (e == 11'h7FF) begin
            r.exp = 1024;
            r.man = {1'b0, fr};
            r.cls = (fr == 0) ? 6'b010000 : (fr[51] ? 6'b001000 : 6'b000100);
        end else if (e == 0 && fr == 0) begin
            r.cls = 6'b100000;
        end else if (e == 0) begin
            lz = 1;
            for (int i = 51; i >= 0 && !fr[i]; i--) lz++;
            r.man = {1'b0, fr} << lz;
            r.exp = -1022 - lz;
            r.lat = 1 + lz / STEP + lz % STEP;
            r.cls = 6'b000010;
        end else begin
            r.exp = int'(e) - 1023;
            r.man = {1'b1, fr};
            r.cls = 6'b000001;
        end
        return r;
    endfunction

    // Scoreboard: one pop per consumed result.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected result", sbq.size(), 1);
            end else begin
                e = sbq.pop_front();
                chk("sign", bus.out_sign, e.sign);
                chk("exp", bus.out_exp, e.exp);
                chk("man", bus.out_man, e.man);
                chk("class", cls_now(), e.cls);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] f, input bit keep);
        int w;
        w = 0;
        sbq.push_back(model(f));
        bus.in_valid = 1'b1;
        bus.in_f     = f;
        #0;
        while (!bus.in_ready && w < 200) begin
            tick();
            w++;
        end
        chk("accept wait", bus.in_ready, 1);
        @(posedge clk);
        #1;
        if (!keep) bus.in_valid = 1'b0;
    endtask

    // Called right after the accept edge; lat counts that edge as 1.
    task automatic wait_out(input string tag, input int lat_req, output int lowcnt);
        int lat;
        lat    = 1;
        lowcnt = 0;
        while (!bus.out_valid && lat < 200) begin
            if (!bus.in_ready) lowcnt++;
            tick();
            lat++;
        end
        chk(tag, lat, lat_req);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          low;
        exp_t        m;
        logic [52:0] hold_man;
        logic [63:0] v;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_f      = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("reset in_ready", bus.in_ready, 0);
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset man", bus.out_man, 0);
        chk("reset cls", cls_now(), 0);
        rst_n = 1'b1;
        #1;

        // Reset in the middle of a denormal shift
        send(64'h0000000000000001, 1'b0);
        repeat (5) tick();
        chk("midshift out_valid", bus.out_valid, 0);
        rst_n = 1'b0;
        #1;
        chk("midshift rst in_ready", bus.in_ready, 0);
        chk("midshift rst out_valid", bus.out_valid, 0);
        sbq.delete();
        tick();
        rst_n = 1'b1;
        #1;
        chk("post rst in_ready", bus.in_ready, 1);
        chk("post rst out_valid", bus.out_valid, 0);
        chk("post rst man", bus.out_man, 0);
        chk("post rst exp", bus.out_exp, 0);
        chk("post rst sign", bus.out_sign, 0);
        chk("post rst cls", cls_now(), 0);
        tick();
        chk("post rst idle", bus.out_valid, 0);

        // Normal 1.0, latency 1
        send(64'h3FF0000000000000, 1'b0);
        chk("norm latency", bus.out_valid, 1);
        tick();
        chk("norm consumed", bus.out_valid, 0);

        // Smallest denormal: lz=52 -> 13 coarse steps
        v = 64'h0000000000000001;
        m = model(v);
        send(v, 1'b0);
        wait_out("dn1 latency", m.lat, low);
        chk("dn1 in_ready low cycles", low, 13);
        tick();

        // Largest-exponent denormal: lz=1
        v = 64'h0008000000000000;
        m = model(v);
        send(v, 1'b0);
        wait_out("dn2 latency", m.lat, low);
        tick();

        // Special-value stream with no bubbles
        send(64'h7FF8000000000000, 1'b1);
        chk("stream qnan valid", bus.out_valid, 1);
        send(64'h7FF0000000000001, 1'b1);
        chk("stream snan valid", bus.out_valid, 1);
        send(64'hFFF0000000000000, 1'b1);
        chk("stream inf valid", bus.out_valid, 1);
        send(64'h8000000000000000, 1'b0);
        chk("stream zero valid", bus.out_valid, 1);
        tick();

        // Backpressure with a pending operand, then consume+accept together
        bus.out_ready = 1'b0;
        v = 64'h4000000000000000;
        hold_man = model(v).man;
        send(v, 1'b1);
        v = 64'hC008000000000000;
        sbq.push_back(model(v));
        bus.in_f = v;
        for (int i = 0; i < 3; i++) begin
            chk("hold in_ready", bus.in_ready, 0);
            chk("hold out_valid", bus.out_valid, 1);
            chk("hold man", bus.out_man, hold_man);
            chk("hold exp", bus.out_exp, 1);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("release in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("release new valid", bus.out_valid, 1);
        chk("release new sign", bus.out_sign, 1);
        tick();

        // Denormal accepted from OUT: out_valid drops while shifting
        send(64'h3FF0000000000000, 1'b1);
        v = 64'h0004000000000000;
        m = model(v);
        sbq.push_back(m);
        bus.in_f = v;
        #0;
        chk("out->shift in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("out->shift valid drop", bus.out_valid, 0);
        wait_out("dn3 latency", m.lat, low);
        tick();

        repeat (3) tick();
        chk("scoreboard drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fp_unpack_seq.md
Name: fp_unpack_seq

Overview:
- Parametrised, handshaked successor to the combinational FP classifier.
- Accepts one IEEE-754-style operand per transaction. Registers its sign and class flags (including quiet/signalling NaN split), unbiased exponent and explicit-leading-one mantissa.
- Denormals are fully normalised by an iterative shifter, STEP bits per cycle.
- Sits at the front of the FPU arithmetic pipeline, feeding add/mul datapaths with pre-normalised operands.

Parameters:
- N_EXP, 11, exponent field width.
- N_MAN, 52, fraction field width.
- BIAS, (1<<(N_EXP-1))-1, exponent bias.
- EMIN, 1-BIAS, minimum normal unbiased exponent.
- STEP, 4, coarse shift per cycle; power of 2, 1..N_MAN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept operand this cycle.
- in_f  in  N_EXP+N_MAN+1  packed operand {sign, exp field, fraction}.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sign  out  1  operand sign.
- out_exp  out  N_EXP+2  signed unbiased exponent.
- out_man  out  N_MAN+1  mantissa, bit N_MAN is the explicit integer bit.
- out_zero, out_inf, out_qnan, out_snan, out_dnorm, out_norm  out  1 each  class flags; exactly one set while out_valid.

Behaviour:
- Reset: asynchronous on rst_n low. State=IDLE; out_valid=0; in_ready=0 while rst_n low; all data outputs and flags=0. Reset mid-shift discards the operand with no output.
- States:
  - IDLE: output register empty.
  - SHIFT: denormal normalising.
  - OUT: result held.
- Handshake:
  - Input accepted on an edge with in_valid & in_ready.
  - Output consumed on an edge with out_valid & out_ready.
  - in_ready = (state==IDLE) | (state==OUT & out_ready). This allows back-to-back throughput of 1/cycle for non-denormals.
  - in_ready=0 throughout SHIFT.
  - out_valid=1 only in OUT. Outputs are stable while out_valid & !out_ready.
- Classification (e1 = exp field all ones, e0 = exp field all zero, f0 = fraction zero):
  - zero = e0&f0: exp=0, man=0.
  - inf = e1&f0: exp=BIAS+1, man=0.
  - qnan = e1&!f0&frac[N_MAN-1]; snan = e1&!f0&!frac[N_MAN-1]: exp=BIAS+1, man={0,frac}.
  - norm = !e1&!e0: exp=field-BIAS, man={1,frac}.
  - dnorm = e0&!f0: see below.
- Non-denormal accept: results written at the accept edge, state->OUT, out_valid high the next cycle (latency 1).
- Denormal accept: man reg={0,frac}, exp reg=EMIN, dnorm flag latched, state->SHIFT. Each SHIFT cycle:
  - If man[N_MAN:N_MAN-STEP+1]==0: shift man left by STEP, exp -= STEP.
  - Else: shift left by 1, exp -= 1.
  - When the shifted man[N_MAN]==1: state->OUT at that edge.
- Denormal result: man MSB=1, exp = EMIN - lz, where lz = leading zeros of {0,frac} from bit N_MAN.
- Denormal latency: out_valid rises 1 + floor(lz/STEP) + (lz mod STEP) cycles after the accept edge.
- Width rule: exp is computed signed in N_EXP+2 bits; EMIN-N_MAN and BIAS+1 are always representable. No wrap.
- Simultaneous events:
  - In OUT with out_ready & in_valid: the old result is consumed and the new operand accepted on the same edge.
  - In that case the next state is OUT (non-denormal) or SHIFT (denormal; out_valid drops).
- in_f is ignored when not accepted.

Test Plan:
- Reset asserted mid-SHIFT (operand 0x0000000000000001, 5 cycles in) -> out_valid=0, state IDLE, in_ready=1 after release, all outputs 0.
- in_f=0x3FF0000000000000, out_ready=1 -> 1 cycle later: out_norm=1, out_exp=0, out_man=1<<52, out_sign=0.
- in_f=0x0000000000000001, STEP=4 -> out_valid exactly 14 cycles after accept; out_dnorm=1, out_exp=-1074, out_man=1<<52; in_ready=0 during the 13 shift cycles.
- in_f=0x0008000000000000 -> latency 2, out_exp=-1023, out_man=1<<52.
- Stream 0x7FF8000000000000, 0x7FF0000000000001, 0xFFF0000000000000, 0x8000000000000000 at 1/cycle with out_ready=1 -> qnan; snan; inf with sign=1, exp=1024; zero with sign=1, exp=0. No bubbles.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; on release, consume and accept occur on the same edge.
